result_streamer: RTL
====================

// Module: result_streamer
// PURPOSE
//  Output path of the TPU: streams result words out of the on-chip result memory to the host.
//  On a start command it reads COUNT words from BASE_ADDR upward through a 1-cycle-latency
//  synchronous read port. Each word is split into OUT_WIDTH-bit beats on a valid/ready host link.
//  Sits between the accumulator/unified-buffer read port and the host interface, opposite the input loader.
// PARAMETERS
//  DATA_WIDTH  16  width of one result word in memory
//  OUT_WIDTH    8  width of one host beat; DATA_WIDTH % OUT_WIDTH == 0 required
//  ADDR_WIDTH   5  memory address width; also width of base_addr
//  CNT_WIDTH    6  width of count (max words per transfer = 2^CNT_WIDTH-1)
// PORTS
//  clk          in   1           clock, all logic on rising edge
//  reset        in   1           synchronous, active-low reset
//  start        in   1           begin transfer; sampled only in IDLE
//  base_addr    in   ADDR_WIDTH  first word address, latched on accepted start
//  count        in   CNT_WIDTH   number of words, latched on accepted start
//  mem_rd_en    out  1           memory read strobe
//  mem_rd_addr  out  ADDR_WIDTH  memory read address
//  mem_rd_data  in   DATA_WIDTH  read data, valid the cycle after mem_rd_en
//  tx_data      out  OUT_WIDTH   host beat
//  tx_valid     out  1           tx_data valid
//  tx_ready     in   1           host accepts beat when tx_valid && tx_ready at clk edge
//  busy         out  1           high in any state other than IDLE
//  done         out  1           one-cycle pulse when transfer completes
// BEHAVIOUR
//  - Reset (reset==0 at edge): state=IDLE; mem_rd_en=0, mem_rd_addr=0, tx_valid=0, tx_data=0,
//    busy=0, done=0; pointers/counters cleared. Reset mid-transfer aborts immediately, no done pulse.
//  - BEATS = DATA_WIDTH/OUT_WIDTH. Beats sent little-endian: bits [OUT_WIDTH-1:0] first.
//  - FSM states IDLE, READ, LOAD, SEND, FIN:
//    IDLE: start=1 -> latch base_addr/count; count==0 -> FIN, else -> READ. start ignored elsewhere.
//    READ: mem_rd_en=1, mem_rd_addr=ptr for exactly one cycle -> LOAD.
//    LOAD: capture mem_rd_data into shift register, beat_idx=0 -> SEND.
//    SEND: tx_valid=1, tx_data=shreg[OUT_WIDTH-1:0]. On handshake: shift right by OUT_WIDTH,
//          beat_idx++. Last beat of word: words_left--, ptr++; words_left==0 -> FIN, else -> READ.
//    FIN:  done=1 for one cycle -> IDLE (busy=0 in that IDLE cycle; new start accepted there).
//  - Latency: start accepted at edge N -> READ in cycle N+1, LOAD N+2, tx_valid first high N+3.
//    Per word with tx_ready held high: 2 + BEATS cycles.
//  - tx_data/tx_valid stable while tx_valid && !tx_ready; tx_valid never drops without handshake.
//  - ptr wraps modulo 2^ADDR_WIDTH (base 31, count 2 reads 31 then 0).
//  - mem_rd_addr holds last issued address when mem_rd_en=0; no read issued outside READ.
//  - start asserted while busy: ignored, latched base/count unchanged.
//  - start held high through FIN->IDLE: new transfer accepted in that IDLE cycle.
// TESTING
//  1 Single word: mem[4]=16'hBEEF, start base=4 count=1, tx_ready=1 -> beats EF,BE on
//    cycles N+3,N+4; done pulse N+5; mem_rd_en high only cycle N+1.
//  2 Backpressure: mem[0..2]=0x0102,0x0304,0x0506, count=3, tx_ready toggled 1-of-3 cycles ->
//    beats 02,01,04,03,06,05 in order; tx_data never changes while stalled.
//  3 Zero count: start count=0 -> no mem_rd_en, no tx_valid, done pulses at N+1, busy high 1 cycle.
//  4 Wrap: base=31, count=2, mem[31]=0xAA55, mem[0]=0x1234 -> read addrs 31,0; beats 55,AA,34,12.
//  5 Ignored start: start re-pulsed with base=9 mid-transfer -> stream unaffected, single done.
//  6 Reset mid-SEND: reset=0 for 1 cycle during 2nd beat -> all outputs at reset values next cycle,
//    no done; fresh start afterward streams correctly from new base.

Source files
------------

// File: rtl/result_streamer.sv
// result_streamer: reads words from a synchronous result memory and streams them out as little-endian beats on a valid/ready link
module result_streamer #(
  parameter int DATA_WIDTH = 16,
  parameter int OUT_WIDTH  = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]  count,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic [OUT_WIDTH-1:0]  tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic                  done
);
  localparam int BEATS = DATA_WIDTH / OUT_WIDTH;
  localparam int BW = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam logic [2:0] IDLE = 3'd0, READ = 3'd1, LOAD = 3'd2, SEND = 3'd3, FIN = 3'd4;
  logic [2:0] state;
  logic [ADDR_WIDTH-1:0] ptr, last_addr;
  logic [CNT_WIDTH-1:0] words_left;
  logic [DATA_WIDTH-1:0] shreg;
  logic [BW-1:0] beat_idx;
  logic last_beat;
  always_comb begin
    mem_rd_en = state == READ;
    mem_rd_addr = state == READ ? ptr : last_addr;
    tx_valid = state == SEND;
    tx_data = shreg[OUT_WIDTH-1:0];
    busy = state != IDLE;
    done = state == FIN;
    last_beat = beat_idx == BW'(BEATS - 1);
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      ptr <= '0;
      last_addr <= '0;
      words_left <= '0;
      shreg <= '0;
      beat_idx <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          ptr <= base_addr;
          words_left <= count;
          state <= count == '0 ? FIN : READ;
        end
        READ: begin
          last_addr <= ptr;
          state <= LOAD;
        end
        LOAD: begin
          shreg <= mem_rd_data;
          beat_idx <= '0;
          state <= SEND;
        end
        SEND: if (tx_ready) begin
          shreg <= shreg >> OUT_WIDTH;
          beat_idx <= beat_idx + 1'b1;
          if (last_beat) begin
            words_left <= words_left - 1'b1;
            ptr <= ptr + 1'b1;
            state <= words_left == CNT_WIDTH'(1) ? FIN : READ;
          end
        end
        FIN: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
